// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch -- instruction fetch unit feeding the cpu block's Inst input.
//
// Holds a word-addressed instruction memory (2^ADDR_W x 32) that is loaded
// over a valid/ready port while idle, a program counter and a three-state
// controller (IDLE / RUN / HALT). In RUN it issues one registered
// instruction per cycle, with redirect > stall > fetch priority.
//
// Optional feature macro: IFETCH_HALT_DETECT_EN
//   defined   : a fetched word with opcode [31:26] == 6'b111111 is not issued;
//               fetch stops in HALT and 'halted' rises.
//   undefined : such words are issued like any other; HALT is unreachable and
//               'halted' stays 0.
//
// Parameters
//   ADDR_W      word-address width (memory depth 2^ADDR_W)
//   RESET_PC    PC loaded at reset and on every start
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   load_valid   in   program-load word present
//   load_ready   out  load accepted this cycle (high only in IDLE)
//   load_addr    in   word address of load word
//   load_data    in   instruction word to store
//   start        in   begin fetching at RESET_PC (IDLE or HALT)
//   stall        in   hold current Inst / pc
//   redirect     in   taken branch/jump; flush and refetch
//   redirect_pc  in   redirect target word address
//   Inst         out  instruction to cpu
//   inst_valid   out  Inst holds a real fetched word
//   inst_pc      out  address Inst was fetched from
//   halted       out  fetch stopped on halt word
// ============================================================================
module inst_fetch #(
    parameter int unsigned           ADDR_W   = 6,
    parameter logic [ADDR_W-1:0]     RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       Inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [31:0]         mem_r [0:DEPTH-1];

    logic [ADDR_W-1:0]   pc_r;
    logic [ADDR_W-1:0]   pc_nxt_s;
    logic [31:0]         inst_r;
    logic [31:0]         inst_nxt_s;
    logic                inst_valid_r;
    logic                inst_valid_nxt_s;
    logic [ADDR_W-1:0]   inst_pc_r;
    logic [ADDR_W-1:0]   inst_pc_nxt_s;
    logic                halted_r;
    logic                halted_nxt_s;

    logic [31:0]         fetch_word_s;
    logic [ADDR_W-1:0]   pc_inc_s;
    logic                halt_hit_s;
    logic                load_we_s;

    // Word at the current PC; registered into Inst on a fetch edge.
    assign fetch_word_s = mem_r[pc_r];
    // Natural ADDR_W-bit overflow provides the wrap from 2^ADDR_W-1 to 0.
    assign pc_inc_s     = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign load_we_s    = load_valid && (state_r == ST_IDLE);

`ifdef IFETCH_HALT_DETECT_EN
    assign halt_hit_s = (fetch_word_s[31:26] == 6'b111111);
`else
    assign halt_hit_s = 1'b0;
`endif

    // Instruction memory write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (load_we_s) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A redirect (even with stall) overrides a halt in the same cycle.
                if (redirect || stall) begin
                    state_nxt_s = ST_RUN;
                end else if (halt_hit_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath next values per state; everything holds unless updated.
    always_comb begin
        pc_nxt_s         = pc_r;
        inst_nxt_s       = inst_r;
        inst_valid_nxt_s = inst_valid_r;
        inst_pc_nxt_s    = inst_pc_r;
        halted_nxt_s     = halted_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    pc_nxt_s = RESET_PC;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    // Flush the in-flight word; target is fetched next edge.
                    pc_nxt_s         = redirect_pc;
                    inst_nxt_s       = 32'h0000_0000;
                    inst_valid_nxt_s = 1'b0;
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else if (halt_hit_s) begin
                    // Halt word is not issued; pc keeps its address.
                    inst_nxt_s       = 32'h0000_0000;
                    inst_valid_nxt_s = 1'b0;
                    halted_nxt_s     = 1'b1;
                end else begin
                    inst_nxt_s       = fetch_word_s;
                    inst_pc_nxt_s    = pc_r;
                    inst_valid_nxt_s = 1'b1;
                    pc_nxt_s         = pc_inc_s;
                end
            end
            ST_HALT: begin
                inst_nxt_s       = 32'h0000_0000;
                inst_valid_nxt_s = 1'b0;
                if (start) begin
                    pc_nxt_s     = RESET_PC;
                    halted_nxt_s = 1'b0;
                end else begin
                    halted_nxt_s = 1'b1;
                end
            end
            default: begin
                pc_nxt_s         = RESET_PC;
                inst_nxt_s       = 32'h0000_0000;
                inst_valid_nxt_s = 1'b0;
                halted_nxt_s     = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            inst_r       <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            inst_pc_r    <= {ADDR_W{1'b0}};
            halted_r     <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            inst_r       <= inst_nxt_s;
            inst_valid_r <= inst_valid_nxt_s;
            inst_pc_r    <= inst_pc_nxt_s;
            halted_r     <= halted_nxt_s;
        end
    end

    assign load_ready = (state_r == ST_IDLE);
    assign Inst       = inst_r;
    assign inst_valid = inst_valid_r;
    assign inst_pc    = inst_pc_r;
    assign halted     = halted_r;

endmodule
